// File: rtl/seq_pkg.sv
// seq_pkg: shared types, default seeds and the recurrence step for the
// a(n) = a(n-2) + a(n-3) sequence family (generator and checker).
package seq_pkg;

  // Checker FSM states.
  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    TRACK  = 2'd1,
    ERROR  = 2'd2,
    RESYNC = 2'd3
  } seq_chk_state_e;

  // Default seeds a(0), a(1), a(2).
  localparam int unsigned SEQ_SEED0 = 32'd0;
  localparam int unsigned SEQ_SEED1 = 32'd1;
  localparam int unsigned SEQ_SEED2 = 32'd1;

  // Widest data word the recurrence helper supports.
  localparam int SEQ_W_MAX = 64;

  // One recurrence step. Callers truncate the result to their own width,
  // which gives exactly the modulo-2^W sum of a W-bit register.
  function automatic logic [SEQ_W_MAX-1:0] seq_next(
    input logic [SEQ_W_MAX-1:0] h2,
    input logic [SEQ_W_MAX-1:0] h3
  );
    return h2 + h3;
  endfunction

endpackage

// File: rtl/seq_checker_if.sv
// seq_checker_if: valid/ready word link between a sequence generator
// (master) and a sequence checker (slave).
interface seq_checker_if #(
  parameter int W = 32
);
  logic [W-1:0] seq;
  logic         seq_valid;
  logic         seq_ready;

  modport master (output seq, output seq_valid, input seq_ready);
  modport slave  (input seq, input seq_valid, output seq_ready);
endinterface

// File: rtl/seq_hist.sv
// seq_hist: 3-deep history of the recurrence with clear and shift-in,
// producing the next term combinationally. Shared with the generator.
module seq_hist
  import seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [W-1:0] exp
);

  // h1_r = a(n-1), h2_r = a(n-2), h3_r = a(n-3) for the next beat n.
  logic [W-1:0] h1_r;
  logic [W-1:0] h2_r;
  logic [W-1:0] h3_r;

  // History shift register: clear wins over shift, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h1_r <= {W{1'b0}};
      h2_r <= {W{1'b0}};
      h3_r <= {W{1'b0}};
    end else if (clear) begin
      h1_r <= {W{1'b0}};
      h2_r <= {W{1'b0}};
      h3_r <= {W{1'b0}};
    end else if (shift) begin
      h1_r <= din;
      h2_r <= h1_r;
      h3_r <= h2_r;
    end
  end

  assign exp = W'(seq_next(SEQ_W_MAX'(h2_r), SEQ_W_MAX'(h3_r)));

endmodule

// File: rtl/seq_checker.sv
// seq_checker: consumes one word per valid/ready beat and checks it against
// the recurrence a(n) = a(n-2) + a(n-3) seeded SEED0..SEED2. Per-beat
// match/mismatch pulses are registered one cycle after the accepting edge.
// Optional feature macro: SEQ_CHK_RESYNC_EN -- when defined, a mismatch
// re-seeds the history from the next three received words and resumes
// tracking; when undefined, ERROR is held until clear_i or reset.
module seq_checker
  import seq_pkg::*;
#(
  parameter int           W     = 32,
  parameter logic [W-1:0] SEED0 = W'(SEQ_SEED0),
  parameter logic [W-1:0] SEED1 = W'(SEQ_SEED1),
  parameter logic [W-1:0] SEED2 = W'(SEQ_SEED2),
  parameter int           CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  seq_checker_if.slave     seq_if,
  input  logic             clear_i,
  output logic             match_o,
  output logic             mismatch_o,
  output logic [W-1:0]     expected_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] beat_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

`ifdef SEQ_CHK_RESYNC_EN
  localparam seq_chk_state_e MISS_STATE = RESYNC;
`else
  localparam seq_chk_state_e MISS_STATE = ERROR;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_chk_state_e   state_r;
  seq_chk_state_e   state_nx_s;
  logic [1:0]       idx_r;
  logic [1:0]       idx_nx_s;
  logic             ready_r;
  logic             beat_s;
  logic [W-1:0]     seed_s;
  logic [W-1:0]     hist_exp_s;
  logic [W-1:0]     exp_s;
  logic             word_ok_s;
  logic             shift_s;
  logic [W-1:0]     shift_val_s;
  logic             hit_s;
  logic             miss_s;
  logic             match_r;
  logic             mismatch_r;
  logic [W-1:0]     expected_r;
  logic             locked_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;

  // A clear in the same cycle drops the beat entirely.
  assign beat_s    = seq_if.seq_valid & ready_r & ~clear_i;
  assign word_ok_s = (seq_if.seq == exp_s);

  seq_hist #(.W(W)) u_hist (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_i),
    .shift   (shift_s),
    .din     (shift_val_s),
    .exp     (hist_exp_s)
  );

  // Expected word: a seed while priming, the recurrence afterwards.
  always_comb begin
    seed_s = SEED2;
    exp_s  = hist_exp_s;
    case (idx_r)
      2'd0:    seed_s = SEED0;
      2'd1:    seed_s = SEED1;
      default: seed_s = SEED2;
    endcase
    if (state_r == PRIME) begin
      exp_s = seed_s;
    end else begin
      exp_s = hist_exp_s;
    end
  end

  // FSM next state, history control and per-beat verdict.
  always_comb begin
    state_nx_s  = state_r;
    idx_nx_s    = idx_r;
    shift_s     = 1'b0;
    shift_val_s = exp_s;
    hit_s       = 1'b0;
    miss_s      = 1'b0;
    if (beat_s) begin
      shift_s = 1'b1;
      case (state_r)
        PRIME: begin
          if (word_ok_s) begin
            hit_s = 1'b1;
            if (idx_r == 2'd2) begin
              state_nx_s = TRACK;
              idx_nx_s   = 2'd0;
            end else begin
              idx_nx_s = idx_r + 2'd1;
            end
          end else begin
            miss_s     = 1'b1;
            state_nx_s = MISS_STATE;
            idx_nx_s   = 2'd0;
          end
        end
        TRACK: begin
          if (word_ok_s) begin
            hit_s = 1'b1;
          end else begin
            miss_s     = 1'b1;
            state_nx_s = MISS_STATE;
            idx_nx_s   = 2'd0;
          end
        end
        ERROR: begin
          miss_s = 1'b1;
        end
`ifdef SEQ_CHK_RESYNC_EN
        RESYNC: begin
          // Re-seed from the stream itself; these beats are silent.
          shift_val_s = seq_if.seq;
          if (idx_r == 2'd2) begin
            state_nx_s = TRACK;
            idx_nx_s   = 2'd0;
          end else begin
            idx_nx_s = idx_r + 2'd1;
          end
        end
`endif
        default: begin
          shift_s    = 1'b0;
          state_nx_s = PRIME;
          idx_nx_s   = 2'd0;
        end
      endcase
    end else begin
      shift_s = 1'b0;
    end
  end

  // FSM state and beat index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= PRIME;
      idx_r   <= 2'd0;
    end else if (clear_i) begin
      state_r <= PRIME;
      idx_r   <= 2'd0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
    end
  end

  // Ready comes up one clock after reset release and never drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b1;
    end
  end

  // Registered verdict pulses, expected word, lock flag and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_r    <= 1'b0;
      mismatch_r <= 1'b0;
      expected_r <= {W{1'b0}};
      locked_r   <= 1'b0;
      beat_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      match_r    <= 1'b0;
      mismatch_r <= 1'b0;
      expected_r <= {W{1'b0}};
      locked_r   <= 1'b0;
      beat_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      match_r    <= hit_s;
      mismatch_r <= miss_s;
      locked_r   <= (state_nx_s == TRACK);
      if (beat_s) begin
        expected_r <= exp_s;
      end
      if (beat_s && (beat_cnt_r != CNT_MAX)) begin
        beat_cnt_r <= beat_cnt_r + CNT_ONE;
      end
      if (miss_s && (err_cnt_r != CNT_MAX)) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end
    end
  end

  assign seq_if.seq_ready = ready_r;
  assign match_o          = match_r;
  assign mismatch_o       = mismatch_r;
  assign expected_o       = expected_r;
  assign locked_o         = locked_r;
  assign beat_cnt_o       = beat_cnt_r;
  assign err_cnt_o        = err_cnt_r;

endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: scoreboard bench for seq_checker. A 32-bit instance covers
// the main stream cases; an 8-bit instance with 4-bit counters covers
// wrap-around and counter saturation.
module tb_seq_checker;

`ifdef SEQ_CHK_RESYNC_EN
  localparam bit RES = 1'b1;
`else
  localparam bit RES = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  seq_checker_if #(.W(32)) bus32 ();
  seq_checker_if #(.W(8))  bus8 ();

  logic        m32, mm32, lk32;
  logic [31:0] e32;
  logic [15:0] bc32, ec32;
  logic        m8, mm8, lk8;
  logic [7:0]  e8;
  logic [3:0]  bc8, ec8;

  seq_checker #(.W(32), .CNT_W(16)) dut32 (
    .clk(clk), .reset_n(reset_n), .seq_if(bus32), .clear_i(clear),
    .match_o(m32), .mismatch_o(mm32), .expected_o(e32), .locked_o(lk32),
    .beat_cnt_o(bc32), .err_cnt_o(ec32)
  );

  seq_checker #(.W(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .seq_if(bus8), .clear_i(clear),
    .match_o(m8), .mismatch_o(mm8), .expected_o(e8), .locked_o(lk8),
    .beat_cnt_o(bc8), .err_cnt_o(ec8)
  );

  // kind: 0 = match pulse, 1 = mismatch pulse, 2 = silent beat
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  exp_t        ent32, ent8;
  logic [31:0] ref32[0:63];
  logic [7:0]  ref8[0:63];
  logic        acc32, acc8;
  int          n_checks = 0;
  int          n_errs = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Remember which edges accepted a beat (a clear drops the beat).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc32 <= 1'b0;
      acc8  <= 1'b0;
    end else begin
      acc32 <= bus32.seq_valid & bus32.seq_ready & ~clear;
      acc8  <= bus8.seq_valid & bus8.seq_ready & ~clear;
    end
  end

  // Scoreboard for the 32-bit instance.
  always @(negedge clk) begin
    if (reset_n) begin
      if (acc32) begin
        check_eq("sb32_avail", 64'(q32.size() > 0), 64'(1));
        if (q32.size() > 0) begin
          ent32 = q32.pop_front();
          check_eq("match32", 64'(m32), 64'(ent32.kind == 2'd0));
          check_eq("mismatch32", 64'(mm32), 64'(ent32.kind == 2'd1));
          if (ent32.kind != 2'd2) check_eq("expected32", 64'(e32), 64'(ent32.val));
        end
      end else begin
        check_eq("idle32", 64'({m32, mm32}), 64'(0));
      end
    end
  end

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    if (reset_n) begin
      if (acc8) begin
        check_eq("sb8_avail", 64'(q8.size() > 0), 64'(1));
        if (q8.size() > 0) begin
          ent8 = q8.pop_front();
          check_eq("match8", 64'(m8), 64'(ent8.kind == 2'd0));
          check_eq("mismatch8", 64'(mm8), 64'(ent8.kind == 2'd1));
          if (ent8.kind != 2'd2) check_eq("expected8", 64'(e8), 64'(ent8.val));
        end
      end else begin
        check_eq("idle8", 64'({m8, mm8}), 64'(0));
      end
    end
  end

  // Drive one beat after 'gap' idle cycles and queue its expected verdict.
  task automatic send(input bit sel8, input logic [31:0] d, input logic [1:0] kind,
                      input logic [31:0] e, input int gap);
    int t;
    logic rdy;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    t = 0;
    rdy = sel8 ? bus8.seq_ready : bus32.seq_ready;
    while (!rdy && t < 16) begin
      @(posedge clk);
      #1;
      t++;
      rdy = sel8 ? bus8.seq_ready : bus32.seq_ready;
    end
    if (t == 16) check_eq("ready_wait", 64'(rdy), 64'(1));
    if (sel8) begin
      bus8.seq = d[7:0];
      bus8.seq_valid = 1'b1;
      q8.push_back('{kind: kind, val: e});
    end else begin
      bus32.seq = d;
      bus32.seq_valid = 1'b1;
      q32.push_back('{kind: kind, val: e});
    end
    @(posedge clk);
    #1;
    bus8.seq_valid = 1'b0;
    bus32.seq_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic drain_and_count(input string tag, input int bc, input int ec, input bit lk);
    @(negedge clk);
    #1;
    check_eq({tag, "_sb_empty"}, 64'(q32.size()), 64'(0));
    check_eq({tag, "_beat_cnt"}, 64'(bc32), 64'(bc));
    check_eq({tag, "_err_cnt"}, 64'(ec32), 64'(ec));
    check_eq({tag, "_locked"}, 64'(lk32), 64'(lk));
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_ready"}, 64'(bus32.seq_ready), 64'(0));
    check_eq({tag, "_pulses"}, 64'({m32, mm32}), 64'(0));
    check_eq({tag, "_expected"}, 64'(e32), 64'(0));
    check_eq({tag, "_locked"}, 64'(lk32), 64'(0));
    check_eq({tag, "_cnts"}, 64'({bc32, ec32}), 64'(0));
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [31:0] d;
    logic [1:0]  k;
    bus32.seq = 32'd0;
    bus32.seq_valid = 1'b0;
    bus8.seq = 8'd0;
    bus8.seq_valid = 1'b0;
    ref32[0] = 32'd0; ref32[1] = 32'd1; ref32[2] = 32'd1;
    ref8[0] = 8'd0;   ref8[1] = 8'd1;   ref8[2] = 8'd1;
    for (int i = 3; i < 64; i++) begin
      ref32[i] = ref32[i-2] + ref32[i-3];
      ref8[i]  = ref8[i-2] + ref8[i-3];
    end

    // Reset state, then ready one clock after release.
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;
    #1;
    check_eq("ready_late", 64'(bus32.seq_ready), 64'(0));
    @(posedge clk);
    #1;
    check_eq("ready_up", 64'(bus32.seq_ready), 64'(1));

    // Case 1: clean back-to-back stream.
    for (int n = 0; n < 16; n++) begin
      send(1'b0, ref32[n], 2'd0, ref32[n], 0);
      check_eq("c1_lock", 64'(lk32), 64'(n >= 2));
    end
    drain_and_count("c1", 16, 0, 1'b1);
    do_clear();

    // Case 2 (or resync when enabled): beat 8 corrupted.
    for (int n = 0; n < 16; n++) begin
      d = (n == 8) ? 32'd6 : ref32[n];
      k = (n < 8) ? 2'd0 : (n == 8) ? 2'd1 : RES ? ((n < 12) ? 2'd2 : 2'd0) : 2'd1;
      send(1'b0, d, k, ref32[n], 0);
      check_eq("c2_lock", 64'(lk32),
               64'((n >= 2) && (RES ? !((n >= 8) && (n <= 10)) : (n < 8))));
    end
    drain_and_count("c2", 16, RES ? 1 : 8, RES);
    do_clear();

    // Case 3: clean stream with random idle gaps.
    for (int n = 0; n < 16; n++) begin
      send(1'b0, ref32[n], 2'd0, ref32[n], int'($urandom_range(0, 5)));
    end
    drain_and_count("c3", 16, 0, 1'b1);

    // Case 4: 8-bit instance past index 30; counters saturate at 15.
    for (int n = 0; n < 40; n++) begin
      send(1'b1, {24'd0, ref8[n]}, 2'd0, {24'd0, ref8[n]}, 0);
      check_eq("c4_lock", 64'(lk8), 64'(n >= 2));
    end
    @(negedge clk);
    #1;
    check_eq("c4_sb_empty", 64'(q8.size()), 64'(0));
    check_eq("c4_beat_sat", 64'(bc8), 64'(15));
    check_eq("c4_err_cnt", 64'(ec8), 64'(0));
    do_clear();

    // Case 5: reset mid-stream, then a full clean run.
    for (int n = 0; n < 6; n++) begin
      send(1'b0, ref32[n], 2'd0, ref32[n], 0);
    end
    reset_n = 1'b0;
    #1;
    check_zero_outputs("c5_rst");
    q32.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check_eq("c5_ready_late", 64'(bus32.seq_ready), 64'(0));
    @(posedge clk);
    #1;
    check_eq("c5_ready_up", 64'(bus32.seq_ready), 64'(1));
    for (int n = 0; n < 16; n++) begin
      send(1'b0, ref32[n], 2'd0, ref32[n], 0);
    end
    drain_and_count("c5", 16, 0, 1'b1);

    // Clear concurrent with a beat: beat dropped, nothing counted.
    bus32.seq = 32'd0;
    bus32.seq_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    bus32.seq_valid = 1'b0;
    clear = 1'b0;
    check_eq("clr_beat_cnt", 64'(bc32), 64'(0));
    check_eq("clr_locked", 64'(lk32), 64'(0));
    send(1'b0, ref32[0], 2'd0, ref32[0], 0);
    drain_and_count("clr_restart", 1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
